adc_channel_sequencer: RTL and testbench
========================================

Name: adc_channel_sequencer

Overview:
- Schedules conversions of the non-binary SAR ADC controller across NUM_CH analog input-mux channels.
- Per conversion: selects the channel, applies that channel's averaging code, releases the ADC controller, waits for conv_finished, then captures the 12-bit result.
- Results leave through a single-entry valid/ready output register tagged with the channel number.
- Sits between the host/register interface and the ADC control block plus input mux.

Parameters:
- NUM_CH, 4, number of mux channels (2..16).
- RESULT_BITS, 12, ADC result width.
- SETTLE_CYCLES, 4, clocks of mux settling before ADC release (>=1).
- TIMEOUT_CYCLES, 1023, max clocks in CONVERT before abort (used only with ADC_SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-clock pulse; begins a scan.
- continuous  in  1  1 = restart the scan after the last enabled channel; 0 = single scan.
- stop  in  1  one-clock pulse; finish the current conversion, then go IDLE.
- ch_mask  in  NUM_CH  channel enable; bit i = channel i.
- avg_cfg  in  3*NUM_CH  per-channel avg_control code; bits [3i+2:3i] belong to channel i.
- adc_conv_finished  in  1  from ADC control; level, high while a result is valid.
- adc_result  in  RESULT_BITS  from ADC control.
- adc_run  out  1  1 = ADC control released from reset/enabled.
- adc_avg_control  out  3  to ADC control avg_control.
- mux_sel  out  $clog2(NUM_CH)  input mux select.
- out_valid  out  1  result register full.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_data  out  RESULT_BITS  captured result.
- out_ch  out  $clog2(NUM_CH)  channel of out_data.
- busy  out  1  FSM not in IDLE.
- err_timeout  out  1  sticky; cleared by start or rst.

Behaviour:
- Reset values: all outputs 0; FSM IDLE; channel pointer 0.
- IDLE: on start with ch_mask != 0, latch ch_mask; ch_ptr = lowest set bit; go SETTLE. start with ch_mask == 0 is ignored. start while busy is ignored.
- SETTLE:
  - mux_sel = ch_ptr and adc_avg_control = avg_cfg[ch_ptr] are registered on entry.
  - Counter runs SETTLE_CYCLES clocks; adc_run stays 0.
  - Then go CONVERT.
- CONVERT:
  - adc_run = 1.
  - Rising edge of adc_conv_finished (registered previous value 0, current 1) -> CAPTURE next clock.
  - A high level already present on entry is not an edge and is ignored.
- CAPTURE:
  - adc_run = 0.
  - If out_valid == 0, or out_valid & out_ready this cycle: load out_data = adc_result, out_ch = ch_ptr, set out_valid; go NEXT.
  - Otherwise remain in CAPTURE (backpressure stall, no overwrite). The value is taken from a holding register loaded at the edge, so adc_result may change during the stall.
- NEXT:
  - Find the next set bit above ch_ptr in the latched mask, wrapping modulo NUM_CH.
  - If the scan wrapped past the highest set bit: go SETTLE on the lowest channel when continuous == 1 and no stop is pending; otherwise go IDLE.
  - If not wrapped: go SETTLE on the found channel.
  - Single-enabled-channel continuous mode reconverts the same channel.
- stop: sets a pending flag in any non-IDLE state; honoured at NEXT; cleared in IDLE.
- out_valid clears on out_valid & out_ready when no simultaneous load occurs. A simultaneous load keeps out_valid = 1 with the new data.
- ch_mask/avg_cfg changes mid-scan: mask takes effect at the next start; avg_cfg is sampled at each SETTLE entry.
- Latency: start to adc_run = 1 is 1 + SETTLE_CYCLES clocks. Finished edge to out_valid is 2 clocks.
- rst mid-operation: immediate return to reset values; any pending result is lost.

Optional Feature:
- Macro: ADC_SEQ_TIMEOUT_EN.
- Defined:
  - A counter in CONVERT runs up to TIMEOUT_CYCLES with no finished edge.
  - Then: set err_timeout, drop adc_run, skip the channel (no result pushed), go NEXT.
- Undefined: no counter; CONVERT waits indefinitely; err_timeout is tied to 0.

Decomposition:
- Package adc_seq_pkg:
  - state enum (IDLE, SETTLE, CONVERT, CAPTURE, NEXT).
  - avg code constants AVG_NONE=3'b000, AVG_4X=3'b001, AVG_8X=3'b010, AVG_MAX=3'b100.
  - Width helper for the channel index.
- Sub-module adc_seq_next_ch: combinational priority finder taking (mask, ch_ptr) and returning (next_ch, wrapped, first_ch).

Test Plan:
- Single scan, ch_mask=4'b1011, avg_cfg all 000, ADC model returns 100+ch, out_ready=1 -> results (ch0,100),(ch1,101),(ch3,103) in order; busy drops after ch3; mux_sel never 2.
- Backpressure: out_ready=0 during two conversions -> first result held stable; FSM stalls in CAPTURE with adc_run=0; raising out_ready delivers both results in order, none lost.
- Continuous, ch_mask=4'b0100, stop pulsed during the 3rd conversion -> exactly 3 results from ch2; then IDLE.
- Per-channel averaging, avg_cfg ch0=001, ch1=100 -> adc_avg_control reads 001 during ch0 CONVERT and 100 during ch1 CONVERT.
- Latency check, SETTLE_CYCLES=4 -> adc_run rises 5 clocks after start; out_valid rises 2 clocks after the finished edge.
- ADC_SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=15 and ch1 never finishing -> err_timeout set; no ch1 result; ch2 converts next; a later start clears err_timeout. Also pulse rst mid-CONVERT -> all outputs 0 next clock.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared state encoding, averaging codes and width helper for the ADC channel sequencer.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CONVERT = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_NEXT    = 3'd4
    } seq_state_e;

    localparam logic [2:0] AVG_NONE = 3'b000;
    localparam logic [2:0] AVG_4X   = 3'b001;
    localparam logic [2:0] AVG_8X   = 3'b010;
    localparam logic [2:0] AVG_MAX  = 3'b100;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_seq_next_ch.sv
// Combinational priority finder: lowest enabled channel, and the next enabled
// channel above the current pointer with a wrap indication.
module adc_seq_next_ch
    import adc_seq_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CW     = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [CW-1:0]     ch_ptr_i,
    output logic [CW-1:0]     next_ch_o,
    output logic              wrapped_o,
    output logic [CW-1:0]     first_ch_o
);

    logic [CW-1:0] above_s;
    logic          found_s;

    // Scan from the top down so the lowest qualifying index is the last one written.
    always_comb begin
        first_ch_o = '0;
        above_s    = '0;
        found_s    = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            first_ch_o = mask_i[i] ? CW'(i) : first_ch_o;
            above_s    = (mask_i[i] && (CW'(i) > ch_ptr_i)) ? CW'(i) : above_s;
            found_s    = found_s | (mask_i[i] && (CW'(i) > ch_ptr_i));
        end
        wrapped_o = ~found_s;
        next_ch_o = found_s ? above_s : first_ch_o;
    end

endmodule

// File: rtl/adc_channel_sequencer.sv
// Scans enabled mux channels through the SAR ADC controller and queues tagged results.
// Optional conversion watchdog enabled by defining ADC_SEQ_TIMEOUT_EN.
module adc_channel_sequencer
    import adc_seq_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int RESULT_BITS    = 12,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       continuous,
    input  logic                       stop,
    input  logic [NUM_CH-1:0]          ch_mask,
    input  logic [3*NUM_CH-1:0]        avg_cfg,
    input  logic                       adc_conv_finished,
    input  logic [RESULT_BITS-1:0]     adc_result,
    output logic                       adc_run,
    output logic [2:0]                 adc_avg_control,
    output logic [$clog2(NUM_CH)-1:0]  mux_sel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [RESULT_BITS-1:0]     out_data,
    output logic [$clog2(NUM_CH)-1:0]  out_ch,
    output logic                       busy,
    output logic                       err_timeout
);

    localparam int CW = ch_width(NUM_CH);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    seq_state_e             state_q, state_d;
    logic [CW-1:0]          ch_ptr_q, ch_ptr_d;
    logic [NUM_CH-1:0]      mask_q, mask_d;
    logic [SW-1:0]          settle_cnt_q, settle_cnt_d;
    logic [RESULT_BITS-1:0] hold_q, hold_d;
    logic                   stop_pend_q, stop_pend_d;
    logic                   fin_prev_q;

    logic                   adc_run_q, adc_run_d;
    logic [2:0]             avg_q, avg_d;
    logic [CW-1:0]          mux_sel_q, mux_sel_d;
    logic                   out_valid_q, out_valid_d;
    logic [RESULT_BITS-1:0] out_data_q, out_data_d;
    logic [CW-1:0]          out_ch_q, out_ch_d;
    logic                   busy_q, busy_d;

    logic [2:0]             avg_arr_s [NUM_CH];
    logic [NUM_CH-1:0]      find_mask_s;
    logic [CW-1:0]          next_ch_s, first_ch_s;
    logic                   wrapped_s;
    logic                   fin_edge_s, load_s, stop_now_s, enter_settle_s;

`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_q, err_d;
`else
    logic          unused_tmo_s;
    assign unused_tmo_s = (TIMEOUT_CYCLES > 0);
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_avg
        assign avg_arr_s[g] = avg_cfg[3*g +: 3];
    end

    // In IDLE the finder looks at the live mask to pick the first channel of a new scan.
    assign find_mask_s = (state_q == ST_IDLE) ? ch_mask : mask_q;

    adc_seq_next_ch #(
        .NUM_CH (NUM_CH),
        .CW     (CW)
    ) u_next_ch (
        .mask_i     (find_mask_s),
        .ch_ptr_i   (ch_ptr_q),
        .next_ch_o  (next_ch_s),
        .wrapped_o  (wrapped_s),
        .first_ch_o (first_ch_s)
    );

    assign fin_edge_s = ~fin_prev_q & adc_conv_finished;
    assign load_s     = (state_q == ST_CAPTURE) && (!out_valid_q || out_ready);
    assign stop_now_s = stop_pend_q | stop;

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ch_ptr_q     <= '0;
            mask_q       <= '0;
            settle_cnt_q <= '0;
            hold_q       <= '0;
            stop_pend_q  <= 1'b0;
            fin_prev_q   <= 1'b0;
            adc_run_q    <= 1'b0;
            avg_q        <= AVG_NONE;
            mux_sel_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_ptr_q     <= ch_ptr_d;
            mask_q       <= mask_d;
            settle_cnt_q <= settle_cnt_d;
            hold_q       <= hold_d;
            stop_pend_q  <= stop_pend_d;
            fin_prev_q   <= adc_conv_finished;
            adc_run_q    <= adc_run_d;
            avg_q        <= avg_d;
            mux_sel_q    <= mux_sel_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            busy_q       <= busy_d;
        end
    end

`ifdef ADC_SEQ_TIMEOUT_EN
    // Conversion watchdog counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    // Next-state and sequencing datapath.
    always_comb begin
        state_d      = state_q;
        ch_ptr_d     = ch_ptr_q;
        mask_d       = mask_q;
        settle_cnt_d = settle_cnt_q;
        hold_d       = hold_q;
        stop_pend_d  = stop_now_s;
`ifdef ADC_SEQ_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        err_d        = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                stop_pend_d = 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
                err_d = start ? 1'b0 : err_q;
`endif
                if (start && (ch_mask != '0)) begin
                    mask_d       = ch_mask;
                    ch_ptr_d     = first_ch_s;
                    settle_cnt_d = '0;
                    state_d      = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_CONVERT;
`ifdef ADC_SEQ_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end else begin
                    settle_cnt_d = settle_cnt_q + SW'(1);
                end
            end
            ST_CONVERT: begin
                if (fin_edge_s) begin
                    hold_d  = adc_result;
                    state_d = ST_CAPTURE;
                end
`ifdef ADC_SEQ_TIMEOUT_EN
                else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_NEXT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
`else
                else begin
                    state_d = ST_CONVERT;
                end
`endif
            end
            ST_CAPTURE: begin
                if (load_s) begin
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_NEXT: begin
                settle_cnt_d = '0;
                if (stop_now_s) begin
                    state_d = ST_IDLE;
                end else if (!wrapped_s) begin
                    ch_ptr_d = next_ch_s;
                    state_d  = ST_SETTLE;
                end else if (continuous) begin
                    ch_ptr_d = first_ch_s;
                    state_d  = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next values; mux select and averaging code are sampled on SETTLE entry.
    always_comb begin
        enter_settle_s = (state_d == ST_SETTLE) && (state_q != ST_SETTLE);
        adc_run_d      = (state_d == ST_CONVERT);
        busy_d         = (state_d != ST_IDLE);
        mux_sel_d      = enter_settle_s ? ch_ptr_d : mux_sel_q;
        avg_d          = enter_settle_s ? avg_arr_s[ch_ptr_d] : avg_q;
        out_data_d     = load_s ? hold_q : out_data_q;
        out_ch_d       = load_s ? ch_ptr_q : out_ch_q;
        if (load_s) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    assign adc_run         = adc_run_q;
    assign adc_avg_control = avg_q;
    assign mux_sel         = mux_sel_q;
    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign out_ch          = out_ch_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// Directed bench for adc_channel_sequencer with a result-queue model and per-cycle checks.
module tb_adc_channel_sequencer;
    import adc_seq_pkg::*;

    localparam int NUM_CH = 4;
    localparam int RB     = 12;
    localparam int SETTLE = 4;
    localparam int TMO    = 15;

    logic              clk = 1'b0;
    logic              rst, start, continuous, stop, out_ready;
    logic [NUM_CH-1:0] ch_mask;
    logic [3*NUM_CH-1:0] avg_cfg;
    logic              adc_conv_finished;
    logic [RB-1:0]     adc_result;
    logic              adc_run, out_valid, busy, err_timeout;
    logic [2:0]        adc_avg_control;
    logic [1:0]        mux_sel, out_ch;
    logic [RB-1:0]     out_data;

    int n_checks = 0;
    int n_errors = 0;
    int n_deliv  = 0;
    logic [3:0] cur_mask  = 4'b0000;
    logic [3:0] dead_mask = 4'b0000;
    logic       chk_en    = 1'b0;

    typedef struct { int ch; int data; } res_t;
    res_t exp_q[$];

    always #5 clk = ~clk;

    adc_channel_sequencer #(
        .NUM_CH(NUM_CH), .RESULT_BITS(RB), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .stop(stop),
        .ch_mask(ch_mask), .avg_cfg(avg_cfg), .adc_conv_finished(adc_conv_finished),
        .adc_result(adc_result), .adc_run(adc_run), .adc_avg_control(adc_avg_control),
        .mux_sel(mux_sel), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .busy(busy), .err_timeout(err_timeout)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Expected results: every enabled, responsive channel in ascending order, once per scan.
    function automatic void push_scan(input logic [3:0] m, input int reps);
        for (int r = 0; r < reps; r++)
            for (int c = 0; c < NUM_CH; c++)
                if (m[c] && !dead_mask[c]) exp_q.push_back('{c, 100 + c});
    endfunction

    task automatic do_start(input logic [3:0] m, input logic cont);
        ch_mask    = m;
        cur_mask   = m;
        continuous = cont;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk(name, int'(busy), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_adc_run"}, int'(adc_run), 0);
        chk({tag, "_avg"}, int'(adc_avg_control), 0);
        chk({tag, "_mux"}, int'(mux_sel), 0);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_data"}, int'(out_data), 0);
        chk({tag, "_ch"}, int'(out_ch), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_err"}, int'(err_timeout), 0);
    endtask

    // ADC controller model: finishes 3 clocks into a run with result 100 + channel.
    initial begin : adc_model
        int conv_cnt;
        adc_conv_finished = 1'b0;
        adc_result        = 12'hABC;
        conv_cnt          = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !adc_run) begin
                adc_conv_finished = 1'b0;
                adc_result        = 12'hABC;
                conv_cnt          = 0;
            end else if (!adc_conv_finished && !dead_mask[mux_sel]) begin
                conv_cnt++;
                if (conv_cnt >= 3) begin
                    adc_conv_finished = 1'b1;
                    adc_result        = RB'(100 + int'(mux_sel));
                end
            end
        end
    end

    // Per-cycle compare against the model, sampled mid-cycle.
    logic          prev_hold = 1'b0;
    logic [RB-1:0] prev_data = '0;
    logic [1:0]    prev_ch   = '0;
    always @(negedge clk) begin : cmp
        res_t e;
        if (chk_en) begin
            if (adc_run) begin
                chk("mux_enabled", int'(cur_mask[mux_sel]), 1);
                chk("avg_code", int'(adc_avg_control), int'(avg_cfg[3*mux_sel +: 3]));
            end
            if (prev_hold) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_data", int'(out_data), int'(prev_data));
                chk("stall_ch", int'(out_ch), int'(prev_ch));
            end
            if (out_valid && out_ready) begin
                n_deliv++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", int'(out_ch), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_ch", int'(out_ch), e.ch);
                    chk("res_data", int'(out_data), e.data);
                end
            end
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        prev_ch   = out_ch;
    end

    initial begin : main
        int d0, n, rises;
        logic prev_run, seen2;
        int seen_avg [NUM_CH];
        rst = 1'b1; start = 1'b0; continuous = 1'b0; stop = 1'b0;
        ch_mask = '0; avg_cfg = '0; out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_all_zero("reset");
        chk_en = 1'b1;

        // Single scan over channels 0,1,3.
        d0 = n_deliv; seen2 = 1'b0;
        push_scan(4'b1011, 1);
        do_start(4'b1011, 1'b0);
        n = 0;
        while (busy && n < 300) begin
            if (mux_sel == 2'd2) seen2 = 1'b1;
            tick();
            n++;
        end
        chk("scan_idle", int'(busy), 0);
        tick();
        chk("scan_count", n_deliv - d0, 3);
        chk("scan_mux2", int'(seen2), 0);

        // Per-channel averaging codes.
        avg_cfg = {3'b000, 3'b000, AVG_MAX, AVG_4X};
        for (int i = 0; i < NUM_CH; i++) seen_avg[i] = -1;
        push_scan(4'b0011, 1);
        do_start(4'b0011, 1'b0);
        n = 0;
        while (busy && n < 300) begin
            if (adc_run) seen_avg[mux_sel] = int'(adc_avg_control);
            tick();
            n++;
        end
        chk("avg_idle", int'(busy), 0);
        chk("avg_ch0", seen_avg[0], 1);
        chk("avg_ch1", seen_avg[1], 4);

        // Backpressure: second result stalls in capture until the consumer is ready.
        avg_cfg = '0; out_ready = 1'b0; d0 = n_deliv;
        push_scan(4'b0011, 1);
        do_start(4'b0011, 1'b0);
        repeat (40) tick();
        chk("bp_valid", int'(out_valid), 1);
        chk("bp_data", int'(out_data), 100);
        chk("bp_ch", int'(out_ch), 0);
        chk("bp_run", int'(adc_run), 0);
        chk("bp_busy", int'(busy), 1);
        chk("bp_mux", int'(mux_sel), 1);
        out_ready = 1'b1;
        wait_idle("bp_idle", 100);
        tick();
        chk("bp_count", n_deliv - d0, 2);
        chk("bp_drained", int'(out_valid), 0);

        // Continuous on channel 2 with stop during the third conversion.
        d0 = n_deliv; rises = 0; prev_run = 1'b0; n = 0;
        push_scan(4'b0100, 3);
        do_start(4'b0100, 1'b1);
        while (rises < 3 && n < 300) begin
            if (adc_run && !prev_run) rises++;
            prev_run = adc_run;
            if (rises < 3) tick();
            n++;
        end
        chk("cont_rises", rises, 3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle("cont_idle", 200);
        continuous = 1'b0;
        tick();
        chk("cont_count", n_deliv - d0, 3);

        // Latency: start to adc_run, and finished edge to out_valid.
        push_scan(4'b0001, 1);
        ch_mask = 4'b0001; cur_mask = 4'b0001; start = 1'b1;
        tick();
        start = 1'b0; n = 1;
        while (!adc_run && n < 50) begin tick(); n++; end
        chk("lat_run", n, 5);
        n = 0;
        while (!adc_conv_finished && n < 50) begin tick(); n++; end
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        chk("lat_valid", n, 2);
        wait_idle("lat_idle", 50);
        tick();

`ifdef ADC_SEQ_TIMEOUT_EN
        // Channel 1 never finishes: it is skipped and the timeout flag latches.
        dead_mask = 4'b0010; d0 = n_deliv;
        push_scan(4'b0111, 1);
        do_start(4'b0111, 1'b0);
        wait_idle("tmo_idle", 300);
        tick();
        chk("tmo_err", int'(err_timeout), 1);
        chk("tmo_count", n_deliv - d0, 2);
        dead_mask = 4'b0000;
        push_scan(4'b0001, 1);
        do_start(4'b0001, 1'b0);
        chk("tmo_clear", int'(err_timeout), 0);
        wait_idle("tmo_idle2", 100);
        tick();
`else
        chk("err_tied", int'(err_timeout), 0);
`endif

        // Reset in the middle of a conversion with a result pending.
        out_ready = 1'b0;
        do_start(4'b0011, 1'b0);
        n = 0;
        while (!(adc_run && mux_sel == 2'd1) && n < 100) begin tick(); n++; end
        chk("rst_in_convert", int'(adc_run && out_valid), 1);
        chk_en = 1'b0;
        rst = 1'b1;
        tick();
        chk_all_zero("midrst");
        rst = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        tick();

        chk("model_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
